// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer at the FFT tail: frames arrive in bit-reversed bin
// order, get scattered into one bank, and stream out of the other in natural order.
module fft_out_reorder #(
  parameter int WIDTH = 24,
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] din_r,
  input  logic signed [WIDTH-1:0] din_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] dout_r,
  output logic signed [WIDTH-1:0] dout_i,
  output logic                    out_last
);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  // Two banks share one array; the bank bit is the address MSB.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt_reg;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank_reg;
  logic             frame_done;

  state_t           state_reg, state_next;
  logic [LOG2N-1:0] rd_cnt_reg, rd_cnt_next;
  logic             rd_bank_reg, rd_bank_next;
  logic [1:0]       tok_cnt_reg, tok_cnt_next;
  logic             fire;
  logic             consume;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign wr_addr[gi] = wr_cnt_reg[LOG2N-1-gi];
    end
  endgenerate

  assign frame_done = in_valid && (wr_cnt_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[{wr_bank_reg, wr_addr}] <= {din_r, din_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (in_valid) begin
      wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (frame_done) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rd_cnt_reg  <= '0;
      rd_bank_reg <= 1'b0;
      tok_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      rd_cnt_reg  <= rd_cnt_next;
      rd_bank_reg <= rd_bank_next;
      tok_cnt_reg <= tok_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rd_cnt_next  = rd_cnt_reg;
    rd_bank_next = rd_bank_reg;
    fire         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tok_cnt_reg != 2'd0) begin
          fire       = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        fire = 1'b1;
        // A token posted on this very edge still counts, so back-to-back frames never bubble.
        if (rd_cnt_reg == LAST_IDX) begin
          state_next = ((tok_cnt_reg != 2'd0) || frame_done) ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (fire) begin
      rd_cnt_next = rd_cnt_reg + 1'b1;
      if (rd_cnt_reg == LAST_IDX) begin
        rd_bank_next = ~rd_bank_reg;
      end
    end
  end

  assign consume      = fire && (rd_cnt_reg == '0);
  assign tok_cnt_next = tok_cnt_reg + {1'b0, frame_done} - {1'b0, consume};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_last  <= (rd_cnt_reg == LAST_IDX);
      {dout_r, dout_i} <= mem[{rd_bank_reg, rd_cnt_reg}];
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench: the driver predicts each output bin (value and cycle) from
// the bit-reversal rule; a negedge monitor pops and compares.
module tb_fft_out_reorder;
  localparam int W = 24;
  localparam int N = 64;
  localparam int L = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic signed [W-1:0] din_r = '0;
  logic signed [W-1:0] din_i = '0;
  logic out_valid, out_last;
  logic signed [W-1:0] dout_r, dout_i;

  fft_out_reorder #(.WIDTH(W), .N(N), .LOG2N(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int r;
    int i;
    bit last;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int fr_r[N];
  int fr_i[N];
  int mj = 0;
  int next_free = 0;
  int last_acc = 0;

  function automatic int brev(int x);
    int y;
    y = 0;
    for (int b = 0; b < L; b++) if (x[b]) y = y | (1 << (L - 1 - b));
    return y;
  endfunction

  task automatic chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: bin m of a frame is the sample that arrived with index bitrev(m).
  task automatic accept(int r, int i, int edge_no);
    int start;
    fr_r[mj] = r;
    fr_i[mj] = i;
    mj++;
    if (mj == N) begin
      start = (edge_no + 1 > next_free) ? edge_no + 1 : next_free;
      for (int m = 0; m < N; m++) begin
        sb.push_back('{fr_r[brev(m)], fr_i[brev(m)], (m == N - 1), start + m});
      end
      next_free = start + N;
      mj = 0;
      $display("frame complete at edge %0d, expecting bins at edges %0d..%0d", edge_no, start, start + N - 1);
    end
  endtask

  task automatic put(bit v, int r, int i);
    @(negedge clk);
    in_valid = v;
    din_r = W'(r);
    din_i = W'(i);
    if (v) begin
      last_acc = cyc + 1;
      accept(r, i, cyc + 1);
    end
  endtask

  task automatic idle(int n);
    repeat (n) put(1'b0, 0, 0);
  endtask

  // mode 0: bitrev pattern + offset, 1: random, 2: extremes; gap 0 none, 1 alternate, 2 random
  task automatic send_frame(int mode, int off, int gap, int count);
    int r, i;
    for (int j = 0; j < count; j++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) put(1'b0, 0, 0);
      case (mode)
        0: begin r = brev(j) + off; i = -brev(j); end
        1: begin r = int'($urandom_range(0, 16777215)) - 8388608; i = int'($urandom_range(0, 16777215)) - 8388608; end
        default: begin r = (j == 0) ? -8388608 : 0; i = (j == 0) ? 8388607 : 0; end
      endcase
      put(1'b1, r, i);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    mj = 0;
    next_free = 0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout_r", int'(dout_r), 0);
    chk("rst_dout_i", int'(dout_i), 0);
    chk("rst_out_last", int'(out_last), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dout_r", int'(dout_r), e.r);
        chk("dout_i", int'(dout_i), e.i);
        chk("out_last", int'(out_last), int'(e.last));
        chk("bin_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_dout_r", int'(dout_r), 0);
      chk("idle_dout_i", int'(dout_i), 0);
      chk("idle_out_last", int'(out_last), 0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) chk("missing_out", 0, 1);
    end
  end

  initial begin
    int guard;
    do_reset();
    idle(3);

    send_frame(0, 0, 0, N);            // single frame
    idle(80);

    send_frame(0, 0, 0, N);            // three back-to-back frames
    send_frame(0, 100, 0, N);
    send_frame(0, -100, 0, N);
    idle(80);

    send_frame(0, 0, 1, N);            // alternate-cycle input
    idle(80);

    send_frame(2, 0, 0, N);            // extreme values at bin 0
    idle(80);

    send_frame(0, 0, 0, 40);           // partial frame discarded by reset
    do_reset();
    idle(3);
    send_frame(0, 0, 0, N);
    idle(80);

    send_frame(0, 0, 0, N);            // reset while bin 20 is on the output
    while (cyc < last_acc + 20) @(negedge clk);
    in_valid = 1'b0;
    do_reset();
    idle(80);
    send_frame(0, 7, 0, N);
    idle(80);

    for (int f = 0; f < 4; f++) send_frame(1, 0, 2, N);  // random data, random gaps
    idle(2);

    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    idle(3);
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer at the tail of the 64-point FFT pipeline. The last butterfly and delay stage emits complex samples in bit-reversed bin order. This block collects each 64-sample frame into one half of a ping-pong buffer and streams it out in natural bin order, 0 to 63. It is the consumer of the shift-register delay chain and turns the pipeline's scrambled output into an ordered spectrum stream.

## Interface
- WIDTH, 24, bit width of each real and imaginary component (signed two's complement)
- N, 64, frame length; must be a power of two
- LOG2N, 6, log2(N); sets the address and counter width
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  din_r/din_i carry a sample this cycle
- din_r  input  WIDTH  real part, signed, bit-reversed order
- din_i  input  WIDTH  imaginary part, signed, bit-reversed order
- out_valid  output  1  dout_r/dout_i hold a valid bin
- dout_r  output  WIDTH  real part, signed, natural order, registered
- dout_i  output  WIDTH  imaginary part, signed, natural order, registered
- out_last  output  1  high with bin N-1 of each output frame

## Operation
- Storage: two banks, each N x 2·WIDTH. Reads of the memory are not reset. Data passes through unmodified, with no scaling or rounding.
- Write side:
  - wr_cnt (LOG2N bits) counts accepted samples. A sample is accepted on each edge with in_valid=1.
  - The sample with in-frame index j is written to address bitrev(j) of bank wr_bank. bitrev reverses all LOG2N bits, so j=1 goes to 32 and j=6 goes to 24.
  - When j=N-1 is accepted, wr_cnt wraps to 0, wr_bank toggles and a frame-ready token is posted for the bank just filled.
  - Gaps in in_valid only pause wr_cnt.
- Read-side FSM has two states:
  - IDLE: out_valid=0, dout_r=dout_i=0, out_last=0. If a frame-ready token is pending, move to READ with rd_cnt=0 on the next edge.
  - READ: each edge, present bank rd_bank at address rd_cnt on the dout registers and increment rd_cnt.
  - After rd_cnt=N-1 is presented: if another token is pending, continue with rd_cnt=0 on the toggled bank and no bubble. Otherwise return to IDLE.
- Overflow cannot occur. Reading a frame takes exactly N cycles and filling the other bank takes at least N cycles, so writes never reach the bank being read.
- Reset mid-operation:
  - Any partially written frame and any in-progress read are discarded.
  - wr_cnt, rd_cnt, wr_bank and rd_bank return to 0. Pending tokens are cleared.
  - The first sample accepted after reset is j=0.

## Timing
- Reset values: out_valid=0, out_last=0, dout_r=0, dout_i=0, FSM=IDLE.
- Latency: the last sample (j=N-1) of a frame is accepted at edge k.
  - out_valid rises after edge k+1, with bin 0.
  - Bin m is held after edge k+1+m.
  - out_last is high after edge k+N, together with bin N-1.
- Continuous input: frame n+1's last sample lands at edge k+N, so its bin 0 appears after edge k+N+1. out_valid stays high with no gap.
- A token posted on the same edge that the reader finishes a frame is honoured seamlessly; that simultaneous event counts as pending.
- dout_r and dout_i are 0 whenever out_valid=0.

## Test plan
- Single frame, no gaps. Drive din_r=bitrev(j) and din_i=-bitrev(j) for j=0..63.
  - Expect dout_r = 0,1,...,63 and dout_i = 0,-1,...,-63.
  - out_valid high for exactly 64 cycles, starting 1 cycle after the 64th input.
  - out_last only with value 63.
- Three back-to-back frames with frame offsets 0, 100 and -100 added to din_r.
  - Expect 192 consecutive out_valid cycles with no bubble.
  - Each frame is in natural order with the correct offset; out_last fires three times.
- Gapped input: in_valid asserted on alternate cycles for one frame.
  - Output is identical to the first scenario.
  - Output starts 1 cycle after the 64th accepted sample.
- Extremes: din_r=-8388608 and din_i=8388607 at j=0, zeros elsewhere. Expect bin 0 equal to exactly those values, with no sign corruption.
- Reset mid-frame: assert rst_n=0 after 40 samples, release, then send one full frame.
  - Expect all outputs 0 during reset and no output for the partial frame.
  - The full frame emerges correctly, starting from bin 0.
- Reset during READ, at bin 20: out_valid=0 and dout=0 immediately. No further output until a new full frame is written.
